// File: rtl/alu_block_sequencer.sv
// Walks a source image in 2x2 blocks, fetches each block from a 1-cycle-latency RAM,
// runs it through the pixel ALU start/done handshake and presents the result downstream.
module alu_block_sequencer #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [3:0]        opcode_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        alu_opcode,
    output logic              alu_start,
    output logic [31:0]       alu_pixels,
    input  logic              alu_done,
    input  logic [63:0]       alu_result,
    output logic [63:0]       blk_data,
    output logic [15:0]       blk_x,
    output logic [15:0]       blk_y,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RUN,
        OUT
    } state_t;

    localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);
    localparam logic [15:0]       LAST_X   = 16'(IMG_W - 2);
    localparam logic [15:0]       LAST_Y   = 16'(IMG_H - 2);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] row_base;

    logic [ADDR_W-1:0] tl_addr;
    logic [ADDR_W-1:0] tr_addr;
    logic [ADDR_W-1:0] bl_addr;
    logic [ADDR_W-1:0] br_addr;
    logic              last_col;
    logic              last_blk;
    logic [15:0]       next_x;
    logic [15:0]       next_y;
    logic [ADDR_W-1:0] next_row;
    logic [ADDR_W-1:0] next_tl;

    // Block addresses and raster advance are pure adds; row_base carries y*IMG_W.
    always_comb begin
        tl_addr  = row_base + ADDR_W'(blk_x);
        tr_addr  = tl_addr + ADDR_W'(1);
        bl_addr  = tl_addr + ROW_W;
        br_addr  = bl_addr + ADDR_W'(1);
        last_col = (blk_x == LAST_X);
        last_blk = last_col && (blk_y == LAST_Y);
        next_x   = last_col ? 16'd0 : blk_x + 16'd2;
        next_y   = last_col ? blk_y + 16'd2 : blk_y;
        next_row = last_col ? row_base + ROW_STEP : row_base;
        next_tl  = next_row + ADDR_W'(next_x);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row_base   <= '0;
            mem_addr   <= '0;
            alu_opcode <= '0;
            alu_start  <= 1'b0;
            alu_pixels <= '0;
            blk_data   <= '0;
            blk_x      <= '0;
            blk_y      <= '0;
            blk_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        alu_opcode <= opcode_in;
                        blk_x      <= '0;
                        blk_y      <= '0;
                        row_base   <= '0;
                        mem_addr   <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                // The address for read k is on the bus during cnt=k, its data lands at cnt=k+1.
                FETCH: begin
                    cnt <= cnt + 3'd1;
                    case (cnt)
                        3'd0: mem_addr <= tr_addr;
                        3'd1: begin
                            mem_addr         <= bl_addr;
                            alu_pixels[7:0]  <= mem_rdata;
                        end
                        3'd2: begin
                            mem_addr         <= br_addr;
                            alu_pixels[15:8] <= mem_rdata;
                        end
                        3'd3: alu_pixels[23:16] <= mem_rdata;
                        default: begin
                            alu_pixels[31:24] <= mem_rdata;
                            alu_start         <= 1'b1;
                            state             <= RUN;
                        end
                    endcase
                end
                RUN: begin
                    if (alu_done) begin
                        blk_data  <= alu_result;
                        alu_start <= 1'b0;
                        blk_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        if (last_blk) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            blk_x    <= next_x;
                            blk_y    <= next_y;
                            row_base <= next_row;
                            mem_addr <= next_tl;
                            cnt      <= '0;
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_block_sequencer.sv
// Bench for alu_block_sequencer on a 4x4 image: RAM and ALU models plus a
// block-level reference computed from image coordinates.
module tb_alu_block_sequencer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          go;
    logic [3:0]    opcode_in;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [3:0]    alu_opcode;
    logic          alu_start;
    logic [31:0]   alu_pixels;
    logic          alu_done;
    logic [63:0]   alu_result;
    logic [63:0]   blk_data;
    logic [15:0]   blk_x;
    logic [15:0]   blk_y;
    logic          blk_valid;
    logic          blk_ready;
    logic          busy;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;
    int done_delay = 1;
    int alu_cnt;
    logic [7:0]  ram [256];
    logic [31:0] first_px;

    alu_block_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .go(go), .opcode_in(opcode_in),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_start(alu_start), .alu_pixels(alu_pixels),
        .alu_done(alu_done), .alu_result(alu_result),
        .blk_data(blk_data), .blk_x(blk_x), .blk_y(blk_y),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_rdata <= ram[mem_addr];

    // ALU: done rises done_delay edges after start is seen, drops once start drops.
    always @(posedge clock) begin
        if (reset || !alu_start) begin
            alu_cnt  <= 0;
            alu_done <= 1'b0;
        end else begin
            alu_cnt <= alu_cnt + 1;
            if (alu_cnt + 1 >= done_delay) alu_done <= 1'b1;
        end
    end
    assign alu_result = {28'h0, alu_opcode, alu_pixels};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [3:0] op, input int delay, input int stall_blk,
                             input int stall_cyc, input bit ready_hi, input bit go_noise,
                             input int abort_blk);
        int n;
        int bx;
        int by;
        logic [31:0] px;
        logic [63:0] dsave;
        logic [AW-1:0] asave;
        done_delay = delay;
        blk_ready  = ready_hi;
        go = 1'b1;
        opcode_in = op;
        step();
        go = 1'b0;
        check("busy_after_go", busy, 1);
        for (int b = 0; b < (W / 2) * (H / 2); b++) begin
            bx = (b % (W / 2)) * 2;
            by = (b / (W / 2)) * 2;
            px = {ram[(by + 1) * W + bx + 1], ram[(by + 1) * W + bx],
                  ram[by * W + bx + 1], ram[by * W + bx]};
            n = 0;
            while (!alu_start && n < 50) begin
                if (go_noise) begin
                    go = 1'b1;
                    opcode_in = ~op;
                end
                step();
                n++;
            end
            check("fetch_len", n, 5);
            check("valid_in_fetch", blk_valid, 0);
            check("pixels", alu_pixels, px);
            check("opcode", alu_opcode, op);
            if (b == 0) first_px = alu_pixels;
            if (b == abort_blk) begin
                step();
                reset = 1'b1;
                go = 1'b0;
                step();
                reset = 1'b0;
                check("abort_start", alu_start, 0);
                check("abort_valid", blk_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_fdone", frame_done, 0);
                check("abort_pixels", alu_pixels, 0);
                check("abort_addr", mem_addr, 0);
                step();
                check("abort_fdone2", frame_done, 0);
                check("abort_busy2", busy, 0);
                return;
            end
            n = 0;
            while (!blk_valid && n < 100) begin
                check("start_held", alu_start, 1);
                check("pix_stable", alu_pixels, px);
                step();
                n++;
            end
            go = 1'b0;
            check("run_len", n, delay + 1);
            check("start_fall", alu_start, 0);
            check("blk_data", blk_data, {28'h0, op, px});
            check("blk_x", blk_x, bx);
            check("blk_y", blk_y, by);
            check("busy_out", busy, 1);
            if (b == stall_blk) begin
                blk_ready = 1'b0;
                dsave = blk_data;
                asave = mem_addr;
                repeat (stall_cyc) begin
                    step();
                    check("stall_valid", blk_valid, 1);
                    check("stall_data", blk_data, dsave);
                    check("stall_addr", mem_addr, asave);
                    check("stall_start", alu_start, 0);
                end
            end
            blk_ready = 1'b1;
            step();
            if (!ready_hi) blk_ready = 1'b0;
            check("valid_drop", blk_valid, 0);
            check("frame_done", frame_done, b == 3);
            check("busy_after_hs", busy, b != 3);
            check("start_after_hs", alu_start, 0);
        end
        step();
        check("fdone_pulse", frame_done, 0);
        check("busy_idle", busy, 0);
        step();
        check("stay_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        go = 1'b0;
        blk_ready = 1'b0;
        opcode_in = 4'd0;
        for (int a = 0; a < 256; a++) ram[a] = 8'(a);
        repeat (3) step();
        check("rst_addr", mem_addr, 0);
        check("rst_start", alu_start, 0);
        check("rst_pixels", alu_pixels, 0);
        check("rst_data", blk_data, 0);
        check("rst_xy", {blk_x, blk_y}, 0);
        check("rst_valid", blk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_opcode", alu_opcode, 0);
        reset = 1'b0;
        step();
        check("idle_busy", busy, 0);

        run_frame(4'd3, 1, -1, 0, 1'b1, 1'b0, -1);
        check("first_block_px", first_px, 32'h05040100);
        check("last_block_lo", blk_data[31:0], 32'h0F0E0B0A);

        run_frame(4'd5, 1, 1, 10, 1'b0, 1'b0, -1);
        run_frame(4'd9, 20, -1, 0, 1'b1, 1'b0, -1);
        run_frame(4'd2, 2, -1, 0, 1'b1, 1'b1, -1);
        check("go_noise_opcode", alu_opcode, 2);
        run_frame(4'd6, 3, -1, 0, 1'b1, 1'b0, 1);
        run_frame(4'd7, 1, -1, 0, 1'b1, 1'b0, -1);
        check("restart_first_px", first_px, 32'h05040100);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < W * H; a++) ram[a] = 8'($urandom);
            run_frame(4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(0, 3),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
